uart_tx_param: RTL and testbench

Parametrised UART transmitter with an on-chip transmit FIFO, configurable frame format and a ready/valid byte interface. It is the next-generation serial TX engine in the custom UART path and sits between a host or bus-side producer and the `tx` pin. Compared with the fixed 8N1 transmitter, it adds:
- baud division;
- 5–9 data bits;
- optional even/odd parity;
- 1 or 2 stop bits;
- buffered back-to-back frames with no idle gap.

---
 rtl/uart_tx_param.sv | 255 +++++++++++++++++++++++++
 tb/tb_uart_tx_param.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: ready/valid byte input, power-of-two TX FIFO,
// 5..9 data bits, optional even/odd parity, 1 or 2 stop bits, back-to-back frames.
module uart_tx_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                               rst_n,
  input  logic                               clk,
  input  logic                               en,
  input  logic [DATA_BITS-1:0]               tx_data,
  input  logic                               tx_valid,
  output logic                               tx_ready,
  output logic                               tx,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [15:0]      BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       DATA_LAST   = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST   = 4'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0] FULL_COUNT  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  function automatic logic frame_parity(input logic [DATA_BITS-1:0] data);
    logic p;
    if (PARITY_MODE == 2) begin
      p = ~(^data);
    end else begin
      p = ^data;
    end
    return p;
  endfunction

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;

  state_e               state_q, state_d;
  logic [15:0]          baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;

  logic                 push;
  logic                 pop;
  logic                 load;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] head;

  // tx_ready depends on the registered count only, so a same-cycle pop never opens a slot
  assign tx_ready   = (count_q != FULL_COUNT);
  assign fifo_empty = (count_q == {CNT_W{1'b0}});
  assign push       = tx_valid && tx_ready;
  assign head       = mem_q[rd_ptr_q];
  assign pop        = load;

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Frame sequencer: state, bit timing and line value
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    load     = 1'b0;

    if (!en) begin
      state_d = S_IDLE;
      tx_d    = 1'b1;
      busy_d  = 1'b0;
      baud_d  = 16'd0;
      bit_d   = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
          end
        end
        S_START: begin
          if (baud_q == 16'd0) begin
            tx_d    = shift_q[0];
            state_d = S_DATA;
            baud_d  = BAUD_RELOAD;
            bit_d   = 4'd0;
          end else begin
            baud_d = baud_q - 16'd1;
          end
        end
        S_DATA: begin
          if (baud_q == 16'd0) begin
            baud_d = BAUD_RELOAD;
            if (bit_q == DATA_LAST) begin
              bit_d = 4'd0;
              if (PARITY_MODE != 0) begin
                state_d = S_PARITY;
                tx_d    = parity_q;
              end else begin
                state_d = S_STOP;
                tx_d    = 1'b1;
              end
            end else begin
              bit_d   = bit_q + 4'd1;
              shift_d = shift_q >> 1;
              tx_d    = shift_q[1];
            end
          end else begin
            baud_d = baud_q - 16'd1;
          end
        end
        S_PARITY: begin
          if (baud_q == 16'd0) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
            baud_d  = BAUD_RELOAD;
            bit_d   = 4'd0;
          end else begin
            baud_d = baud_q - 16'd1;
          end
        end
        S_STOP: begin
          if (baud_q == 16'd0) begin
            if (bit_q == STOP_LAST) begin
              // A pending word starts its start bit on the very next cycle
              if (!fifo_empty) begin
                load = 1'b1;
              end else begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                baud_d  = 16'd0;
                bit_d   = 4'd0;
              end
            end else begin
              bit_d  = bit_q + 4'd1;
              baud_d = BAUD_RELOAD;
            end
          end else begin
            baud_d = baud_q - 16'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          baud_d  = 16'd0;
          bit_d   = 4'd0;
        end
      endcase

      if (load) begin
        shift_d  = head;
        parity_d = frame_parity(head);
        tx_d     = 1'b0;
        busy_d   = 1'b1;
        state_d  = S_START;
        baud_d   = BAUD_RELOAD;
        bit_d    = 4'd0;
      end else begin
        parity_d = parity_d;
      end
    end
  end

  // FIFO storage; reset discards any queued words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {DATA_BITS{1'b0}};
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  // FIFO pointers and count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Sequencer registers, including the registered line and busy outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      baud_q   <= 16'd0;
      bit_q    <= 4'd0;
      shift_q  <= {DATA_BITS{1'b0}};
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: five instances cover 8N1, even/odd parity
// and the 5-bit / 9-bit two-stop-bit extremes, all at 4 clocks per bit.
module tb_uart_tx_param;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] en_v, valid_v, ready_v, tx_v, busy_v;
  logic [7:0] data8 [3];
  logic [4:0] data5;
  logic [8:0] data9;
  logic [2:0] cnt_v [5];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut0 (
    .rst_n(rst_n), .clk(clk), .en(en_v[0]), .tx_data(data8[0]), .tx_valid(valid_v[0]),
    .tx_ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .fifo_count(cnt_v[0]));
  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut1 (
    .rst_n(rst_n), .clk(clk), .en(en_v[1]), .tx_data(data8[1]), .tx_valid(valid_v[1]),
    .tx_ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .fifo_count(cnt_v[1]));
  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut2 (
    .rst_n(rst_n), .clk(clk), .en(en_v[2]), .tx_data(data8[2]), .tx_valid(valid_v[2]),
    .tx_ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .fifo_count(cnt_v[2]));
  uart_tx_param #(.DATA_BITS(5), .CLKS_PER_BIT(CPB), .PARITY_MODE(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut3 (
    .rst_n(rst_n), .clk(clk), .en(en_v[3]), .tx_data(data5), .tx_valid(valid_v[3]),
    .tx_ready(ready_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .fifo_count(cnt_v[3]));
  uart_tx_param #(.DATA_BITS(9), .CLKS_PER_BIT(CPB), .PARITY_MODE(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut4 (
    .rst_n(rst_n), .clk(clk), .en(en_v[4]), .tx_data(data9), .tx_valid(valid_v[4]),
    .tx_ready(ready_v[4]), .tx(tx_v[4]), .busy(busy_v[4]), .fifo_count(cnt_v[4]));

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Offer one word to instance i; it is taken on the following rising edge if ready.
  task automatic push(input int i, input logic [8:0] d);
    @(negedge clk);
    case (i)
      3:       data5 = d[4:0];
      4:       data9 = d;
      default: data8[i] = d[7:0];
    endcase
    valid_v[i] = 1'b1;
    @(posedge clk);
    #1;
    valid_v[i] = 1'b0;
  endtask

  // Sample nbits bit periods starting at the next falling edge; exp lists line levels LSB first.
  task automatic capture(input int i, input int nbits, input logic [15:0] exp, input string tag);
    int busy_cnt;
    logic [CPB-1:0] s;
    busy_cnt = 0;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        s[c] = tx_v[i];
        if (busy_v[i]) busy_cnt++;
      end
      check_eq($sformatf("%s bit%0d", tag, b), 32'(s), exp[b] ? 32'hF : 32'h0);
    end
    check_eq($sformatf("%s busy cycles", tag), 32'(busy_cnt), 32'(nbits * CPB));
  endtask

  task automatic expect_idle(input int i, input string tag);
    @(negedge clk);
    check_eq($sformatf("%s busy", tag), 32'(busy_v[i]), 32'h0);
    check_eq($sformatf("%s tx", tag), 32'(tx_v[i]), 32'h1);
    check_eq($sformatf("%s count", tag), 32'(cnt_v[i]), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    en_v = 5'b0; valid_v = 5'b0;
    for (int k = 0; k < 3; k++) data8[k] = 8'h00;
    data5 = 5'h00; data9 = 9'h000;
    repeat (3) @(negedge clk);
    check_eq("reset tx", 32'(tx_v[0]), 32'h1);
    check_eq("reset busy", 32'(busy_v[0]), 32'h0);
    check_eq("reset count", 32'(cnt_v[0]), 32'h0);
    check_eq("reset ready", 32'(ready_v[0]), 32'h1);
    check_eq("reset tx all", 32'(tx_v), 32'h1F);
    rst_n = 1'b1;

    // Basic 8N1 frame of 0xA5
    en_v[0] = 1'b1;
    push(0, 9'h0A5);
    @(posedge clk);
    capture(0, 10, 16'h034A, "basic A5");
    expect_idle(0, "basic end");

    // Even and odd parity
    en_v[1] = 1'b1; en_v[2] = 1'b1;
    push(1, 9'h007); @(posedge clk); capture(1, 11, 16'h060E, "even 07"); expect_idle(1, "even 07 end");
    push(1, 9'h003); @(posedge clk); capture(1, 11, 16'h0406, "even 03"); expect_idle(1, "even 03 end");
    push(2, 9'h007); @(posedge clk); capture(2, 11, 16'h040E, "odd 07");  expect_idle(2, "odd 07 end");
    push(2, 9'h003); @(posedge clk); capture(2, 11, 16'h0606, "odd 03");  expect_idle(2, "odd 03 end");

    // Two stop bits at 5 and 9 data bits
    en_v[3] = 1'b1; en_v[4] = 1'b1;
    push(3, 9'h016); @(posedge clk); capture(3, 8, 16'h00EC, "d5s2");  expect_idle(3, "d5s2 end");
    push(4, 9'h1A5); @(posedge clk); capture(4, 12, 16'h0F4A, "d9s2"); expect_idle(4, "d9s2 end");

    // Fill the FIFO while disabled, then drain back-to-back
    en_v[0] = 1'b0;
    push(0, 9'h011); push(0, 9'h022); push(0, 9'h033); push(0, 9'h044);
    @(negedge clk);
    check_eq("full count", 32'(cnt_v[0]), 32'h4);
    check_eq("full ready", 32'(ready_v[0]), 32'h0);
    check_eq("full idle tx", 32'(tx_v[0]), 32'h1);
    data8[0] = 8'h55;
    valid_v[0] = 1'b1;
    @(negedge clk);
    valid_v[0] = 1'b0;
    check_eq("fifth rejected", 32'(cnt_v[0]), 32'h4);
    en_v[0] = 1'b1;
    capture(0, 10, 16'h0222, "b2b 11");
    capture(0, 10, 16'h0244, "b2b 22");
    capture(0, 10, 16'h0266, "b2b 33");
    capture(0, 10, 16'h0288, "b2b 44");
    expect_idle(0, "b2b end");

    // Drop enable mid-frame with two words still queued
    en_v[0] = 1'b0;
    push(0, 9'h05A); push(0, 9'h0C3); push(0, 9'h00F);
    @(negedge clk);
    en_v[0] = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("drop pre tx", 32'(tx_v[0]), 32'h0);
    check_eq("drop pre busy", 32'(busy_v[0]), 32'h1);
    check_eq("drop pre count", 32'(cnt_v[0]), 32'h2);
    en_v[0] = 1'b0;
    @(negedge clk);
    check_eq("drop tx", 32'(tx_v[0]), 32'h1);
    check_eq("drop busy", 32'(busy_v[0]), 32'h0);
    check_eq("drop count", 32'(cnt_v[0]), 32'h2);
    en_v[0] = 1'b1;
    capture(0, 10, 16'h0386, "resume C3");
    capture(0, 10, 16'h021E, "resume 0F");
    expect_idle(0, "resume end");

    // Asynchronous reset during the parity bit
    push(1, 9'h007);
    push(1, 9'h003);
    repeat (37) @(posedge clk);
    #2;
    check_eq("pre-reset busy", 32'(busy_v[1]), 32'h1);
    check_eq("pre-reset count", 32'(cnt_v[1]), 32'h1);
    rst_n = 1'b0;
    #1;
    check_eq("async reset tx", 32'(tx_v[1]), 32'h1);
    check_eq("async reset busy", 32'(busy_v[1]), 32'h0);
    check_eq("async reset count", 32'(cnt_v[1]), 32'h0);
    check_eq("async reset ready", 32'(ready_v[1]), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("post-reset tx", 32'(tx_v[1]), 32'h1);
    check_eq("post-reset busy", 32'(busy_v[1]), 32'h0);
    check_eq("post-reset count", 32'(cnt_v[1]), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
